// File: rtl/int_to_floating_point_converter.sv
// int_to_floating_point_converter
//   Three-stage pipelined signed-integer to floating-point converter.
//   Output format is {sign, biased exponent, fraction} with an implicit
//   leading one. One conversion per cycle, no backpressure, bubbles
//   (valid_i=0) travel through the pipeline unchanged.
//
//   Stage 1: sign and unsigned magnitude.
//   Stage 2: leading-one position, left-normalised magnitude, zero flag.
//   Stage 3: round to nearest even, exponent overflow to infinity, pack.
//
// Ports
//   clk_i    clock, rising edge
//   rst_i    synchronous active-high reset; clears the valid pipeline only
//   int_i    two's-complement integer operand (INT_WIDTH bits)
//   valid_i  int_i qualifier
//   fp_o     converted value (1+EXP_WIDTH+FRAC_WIDTH bits)
//   valid_o  fp_o qualifier
module int_to_floating_point_converter #(
    parameter  int INT_WIDTH    = 16,
    parameter  int EXP_WIDTH    = 8,
    parameter  int FRAC_WIDTH   = 23,
    localparam int FP_WIDTH_REG = 1 + EXP_WIDTH + FRAC_WIDTH
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic [INT_WIDTH-1:0]    int_i,
    input  logic                    valid_i,
    output logic [FP_WIDTH_REG-1:0] fp_o,
    output logic                    valid_o
);
    localparam int STAGES = 3;
    localparam int SHW    = $clog2(INT_WIDTH);
    localparam int EW1    = EXP_WIDTH + 1;
    localparam int BIAS   = 2**(EXP_WIDTH-1) - 1;
    // bits below the leading one, followed by enough zero padding that the
    // fraction, guard and sticky fields always exist
    localparam int EXT_W  = (INT_WIDTH - 1) + FRAC_WIDTH + 2;

    // ---------------- valid pipeline ----------------
    logic [STAGES-1:0] vld_pipe;

    always_ff @(posedge clk_i) begin
        if (rst_i) vld_pipe <= '0;
        else       vld_pipe <= {vld_pipe[STAGES-2:0], valid_i};
    end

    assign valid_o = vld_pipe[STAGES-1];

    // ---------------- stage 1: sign / magnitude ----------------
    // Unary minus at INT_WIDTH bits maps -2^(INT_WIDTH-1) onto 2^(INT_WIDTH-1),
    // which is the correct unsigned magnitude.
    logic                 s1_sign;
    logic [INT_WIDTH-1:0] s1_mag;

    always_ff @(posedge clk_i) begin
        s1_sign <= int_i[INT_WIDTH-1];
        s1_mag  <= int_i[INT_WIDTH-1] ? -int_i : int_i;
    end

    // ---------------- stage 2: normalise ----------------
    logic [SHW-1:0]       lead_pos;
    logic [INT_WIDTH-1:0] norm;

    always_comb begin
        lead_pos = '0;
        for (int i = 0; i < INT_WIDTH; i++)
            if (s1_mag[i]) lead_pos = SHW'(i);
    end

    assign norm = s1_mag << (SHW'(INT_WIDTH - 1) - lead_pos);

    logic                 s2_sign;
    logic                 s2_zero;
    logic [SHW-1:0]       s2_pos;
    logic [INT_WIDTH-2:0] s2_below;

    // After normalisation the MSB is set for every non-zero magnitude, so
    // its absence is the zero flag and only the bits below it are kept.
    always_ff @(posedge clk_i) begin
        s2_sign  <= s1_sign;
        s2_zero  <= ~norm[INT_WIDTH-1];
        s2_pos   <= lead_pos;
        s2_below <= norm[INT_WIDTH-2:0];
    end

    // ---------------- stage 3: round / pack ----------------
    logic [EXT_W-1:0]        ext;
    logic [FRAC_WIDTH-1:0]   frac_t;
    logic                    guard_b;
    logic                    sticky_b;
    logic                    round_up;
    logic [FRAC_WIDTH:0]     frac_r;
    logic [EW1-1:0]          exp_w;
    logic [FP_WIDTH_REG-1:0] fp_n;

    // When p <= FRAC_WIDTH the guard and sticky bits fall in the zero
    // padding, so the exact case needs no separate path.
    assign ext      = {s2_below, {(FRAC_WIDTH+2){1'b0}}};
    assign frac_t   = ext[EXT_W-1 -: FRAC_WIDTH];
    assign guard_b  = ext[EXT_W-1-FRAC_WIDTH];
    assign sticky_b = |ext[EXT_W-2-FRAC_WIDTH:0];
    assign round_up = guard_b & (sticky_b | frac_t[0]);
    assign frac_r   = {1'b0, frac_t} + {{FRAC_WIDTH{1'b0}}, round_up};
    // carry out of the mantissa bumps the exponent; the fraction wraps to 0
    assign exp_w    = EW1'(BIAS) + EW1'(s2_pos) + EW1'(frac_r[FRAC_WIDTH]);

    always_comb begin
        fp_n = {s2_sign, exp_w[EXP_WIDTH-1:0], frac_r[FRAC_WIDTH-1:0]};
        if (s2_zero)
            fp_n = '0;
        else if (exp_w >= EW1'(2**EXP_WIDTH - 1))
            fp_n = {s2_sign, {EXP_WIDTH{1'b1}}, {FRAC_WIDTH{1'b0}}};
    end

    always_ff @(posedge clk_i) begin
        fp_o <= fp_n;
    end

endmodule

// File: tb/tb_int_to_floating_point_converter.sv
module tb_int_to_floating_point_converter;

  typedef struct {
    int          sel;
    int          val;
    bit          vld;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          cyc;
  } sb_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in0 = '0, in1 = '0;
  logic [16:0] in2 = '0;
  logic        v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
  logic [31:0] fp0;
  logic [15:0] fp1, fp2;
  logic        vo0, vo1, vo2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  sb_t  q0[$], q1[$], q2[$];
  vec_t tbl[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int_to_floating_point_converter dut0 (
    .clk_i(clk), .rst_i(rst), .int_i(in0), .valid_i(v0), .fp_o(fp0), .valid_o(vo0));

  int_to_floating_point_converter #(.INT_WIDTH(16), .EXP_WIDTH(5), .FRAC_WIDTH(10)) dut1 (
    .clk_i(clk), .rst_i(rst), .int_i(in1), .valid_i(v1), .fp_o(fp1), .valid_o(vo1));

  int_to_floating_point_converter #(.INT_WIDTH(17), .EXP_WIDTH(5), .FRAC_WIDTH(10)) dut2 (
    .clk_i(clk), .rst_i(rst), .int_i(in2), .valid_i(v2), .fp_o(fp2), .valid_o(vo2));

  // reference: convert through an IEEE double, then round its 52-bit
  // mantissa down to fw bits (nearest, ties to even)
  function automatic logic [31:0] model(input int val, input int ew, input int fw);
    logic [63:0]     d;
    longint unsigned m, fr, rem, half;
    longint          e;
    longint unsigned s;
    if (val == 0) return 32'd0;
    d    = $realtobits(real'(val));
    s    = {63'd0, d[63]};
    e    = longint'({53'd0, d[62:52]}) - 1023;
    m    = {12'd0, d[51:0]};
    fr   = m >> (52 - fw);
    rem  = m & ((64'd1 << (52 - fw)) - 64'd1);
    half = 64'd1 << (51 - fw);
    if (rem > half || (rem == half && fr[0])) fr = fr + 64'd1;
    if (fr == (64'd1 << fw)) begin fr = 64'd0; e = e + 1; end
    e = e + longint'((1 << (ew - 1)) - 1);
    if (e >= longint'((1 << ew) - 1)) begin e = longint'((1 << ew) - 1); fr = 64'd0; end
    return 32'((s << (ew + fw)) | (longint'(e) << fw) | fr);
  endfunction

  task automatic set_in(input int sel, input int val, input bit v, input bit push,
                        input logic [31:0] e);
    case (sel)
      0: begin in0 = 16'(val); v0 = v; if (v && push) q0.push_back('{e, cyc}); end
      1: begin in1 = 16'(val); v1 = v; if (v && push) q1.push_back('{e, cyc}); end
      default: begin in2 = 17'(val); v2 = v; if (v && push) q2.push_back('{e, cyc}); end
    endcase
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
  endtask

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, req);
    end
  endtask

  task automatic chk_out(input int k, input logic [31:0] got);
    sb_t e;
    bit  empty;
    case (k)
      0: begin empty = (q0.size() == 0); if (!empty) e = q0.pop_front(); end
      1: begin empty = (q1.size() == 0); if (!empty) e = q1.pop_front(); end
      default: begin empty = (q2.size() == 0); if (!empty) e = q2.pop_front(); end
    endcase
    n_cmp++;
    if (empty) begin
      n_bad++;
      $display("FAIL unexpected_valid dut%0d: got fp %h at cycle %0d, required no output", k, got, cyc);
    end else if (got !== e.exp || cyc != e.cyc + 3) begin
      n_bad++;
      $display("FAIL out dut%0d: got %h at cycle %0d, required %h at cycle %0d",
               k, got, cyc, e.exp, e.cyc + 3);
    end
  endtask

  always @(negedge clk) begin
    if (vo0) chk_out(0, fp0);
    if (vo1) chk_out(1, {16'd0, fp1});
    if (vo2) chk_out(2, {16'd0, fp2});
  end

  task automatic drive_all(input int x);
    logic [15:0] a;
    logic [16:0] b;
    int          va, vb;
    a  = 16'(x);
    b  = 17'(x);
    va = int'($signed(a));
    vb = int'($signed(b));
    set_in(0, va, 1'b1, 1'b1, model(va, 8, 23));
    set_in(1, va, 1'b1, 1'b1, model(va, 5, 10));
    set_in(2, vb, 1'b1, 1'b1, model(vb, 5, 10));
    tick();
  endtask

  initial begin
    // T1: defaults, back-to-back
    tbl.push_back('{0,      1, 1'b1, 32'h3F800000});
    tbl.push_back('{0,      0, 1'b1, 32'h00000000});
    tbl.push_back('{0,     -1, 1'b1, 32'hBF800000});
    tbl.push_back('{0,  32767, 1'b1, 32'h46FFFE00});
    tbl.push_back('{0, -32768, 1'b1, 32'hC7000000});
    // T4: bubbles
    tbl.push_back('{0,      2, 1'b1, 32'h40000000});
    tbl.push_back('{0,     99, 1'b0, 32'h0});
    tbl.push_back('{0,      3, 1'b1, 32'h40400000});
    tbl.push_back('{0,      4, 1'b1, 32'h40800000});
    tbl.push_back('{0,     99, 1'b0, 32'h0});
    // T2: rounding ties and mantissa carry, half-precision format
    tbl.push_back('{1,   2049, 1'b1, 32'h6800});
    tbl.push_back('{1,   2051, 1'b1, 32'h6802});
    tbl.push_back('{1,   2053, 1'b1, 32'h6802});
    tbl.push_back('{1,   2055, 1'b1, 32'h6804});
    tbl.push_back('{1,  32767, 1'b1, 32'h7800});
    tbl.push_back('{1,     -1, 1'b1, 32'hBC00});
    // T3: exponent overflow to infinity
    tbl.push_back('{2,  65535, 1'b1, 32'h7C00});
    tbl.push_back('{2, -65536, 1'b1, 32'hFC00});

    // reset state
    tick(); tick();
    @(negedge clk);
    cmp("reset_valid_dut0", {31'd0, vo0}, 32'd0);
    cmp("reset_valid_dut1", {31'd0, vo1}, 32'd0);
    cmp("reset_valid_dut2", {31'd0, vo2}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      set_in(tbl[i].sel, tbl[i].val, tbl[i].vld, 1'b1, tbl[i].exp);
      tick();
    end
    repeat (5) tick();

    // T5: reset with words in flight; the third word is presented during reset
    set_in(0, 5, 1'b1, 1'b0, 32'h0); tick();
    set_in(0, 6, 1'b1, 1'b0, 32'h0); tick();
    rst = 1'b1;
    set_in(0, 7, 1'b1, 1'b0, 32'h0); tick();
    rst = 1'b0;
    @(negedge clk);
    cmp("valid_after_reset", {31'd0, vo0}, 32'd0);
    @(posedge clk); #1;
    repeat (3) tick();
    set_in(0, 9, 1'b1, 1'b1, 32'h41100000); tick();
    repeat (5) tick();

    // T6: powers of two +/-1 and a random sweep against the reference
    for (int b = 0; b <= 16; b++)
      for (int d = -1; d <= 1; d++) begin
        drive_all((1 << b) + d);
        drive_all(-((1 << b) + d));
      end
    for (int i = 0; i < 3000; i++) drive_all(int'($urandom));

    repeat (8) tick();
    cmp("drain_dut0", q0.size(), 32'd0);
    cmp("drain_dut1", q1.size(), 32'd0);
    cmp("drain_dut2", q2.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion, required finish before 200000");
    $fatal(1);
  end

endmodule
